// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the sequential 8-to-3 encoder.
package enc_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  // Priority-order select values for PRIO_HIGH
  localparam bit PRIO_LOW_FIRST  = 1'b0;
  localparam bit PRIO_HIGH_FIRST = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/encoder8to3_queue_prio_enc8.sv
// Combinational 8-bit priority encoder; direction chosen by PRIO_HIGH.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit PRIO_HIGH = PRIO_LOW_FIRST
) (
  input  logic [N_IN-1:0]   vec,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // Scan so the preferred end is visited last and wins
    if (PRIO_HIGH == PRIO_HIGH_FIRST) begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder8to3_queue.sv
// Collects line events into a pending vector and emits them one at a time
// as 3-bit codes over a valid/ready handshake, in fixed priority order.
module encoder8to3_queue
  import enc_pkg::*;
#(
  parameter bit PRIO_HIGH = PRIO_LOW_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic [N_IN-1:0]   req,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N_IN-1:0]   pending,
  output logic              empty,
  output logic              overflow
);

  state_t              state_reg, state_next;
  logic [N_IN-1:0]     pending_reg, pending_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic                overflow_reg, overflow_next;

  logic [CODE_W-1:0]   sel_idx;
  logic                sel_found;
  logic                load_en;
  logic [N_IN-1:0]     load_mask;
  logic [N_IN-1:0]     set_vec;

  prio_enc8 #(
    .PRIO_HIGH(PRIO_HIGH)
  ) u_prio (
    .vec  (pending_reg),
    .idx  (sel_idx),
    .found(sel_found)
  );

  // The output stage is free when nothing is presented or the current code
  // is being accepted this edge.
  assign load_en   = sel_found && ((state_reg == IDLE) || ready);
  assign load_mask = load_en ? (N_IN'(1) << sel_idx) : '0;
  assign set_vec   = e ? req : '0;

  always_comb begin
    state_next    = state_reg;
    pending_next  = (pending_reg & ~load_mask) | set_vec;
    code_next     = load_en ? sel_idx : code_reg;
    // A new event only counts as lost if it lands on a bit still waiting
    overflow_next = overflow_reg | (|(set_vec & pending_reg & ~load_mask));
    case (state_reg)
      IDLE:    if (sel_found) state_next = PRESENT;
      PRESENT: if (ready && !sel_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      code_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      code_reg     <= code_next;
      overflow_reg <= overflow_next;
    end
  end

  assign code     = code_reg;
  assign valid    = (state_reg == PRESENT);
  assign pending  = pending_reg;
  assign overflow = overflow_reg;
  assign empty    = (pending_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_encoder8to3_queue.sv
// Directed bench: two instances (low-first and high-first priority) share stimulus.
module tb_encoder8to3_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b1;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b1;

  logic [2:0] code, code_hi;
  logic       valid, valid_hi;
  logic [7:0] pending, pending_hi;
  logic       empty, empty_hi;
  logic       overflow, overflow_hi;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  encoder8to3_queue #(.PRIO_HIGH(1'b0)) dut (
    .clk(clk), .rst(rst), .e(e), .req(req), .code(code), .valid(valid),
    .ready(ready), .pending(pending), .empty(empty), .overflow(overflow)
  );

  encoder8to3_queue #(.PRIO_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .e(e), .req(req), .code(code_hi), .valid(valid_hi),
    .ready(ready), .pending(pending_hi), .empty(empty_hi), .overflow(overflow_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks valid, and the code only when a code is expected to be presented.
  task automatic check_out(input string tag, input logic exp_valid, input logic [2:0] exp_code);
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, exp_valid});
    if (exp_valid) check({tag, ".code"}, {5'd0, code}, {5'd0, exp_code});
  endtask

  initial begin
    // 1. Reset with requests active
    rst = 1'b1; e = 1'b1; req = 8'hFF; ready = 1'b1;
    tick(); tick(); tick();
    check("rst.pending", pending, 8'h00);
    check("rst.valid", {7'd0, valid}, 8'h00);
    check("rst.overflow", {7'd0, overflow}, 8'h00);
    check("rst.empty", {7'd0, empty}, 8'h01);
    check("rst.valid_hi", {7'd0, valid_hi}, 8'h00);
    rst = 1'b0; req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst.valid", {7'd0, valid}, 8'h00);
    end
    $display("txn reset: done");

    // 2. Single event
    req = 8'h04; tick();
    check("single.pending", pending, 8'h04);
    check("single.valid0", {7'd0, valid}, 8'h00);
    req = 8'h00; tick();
    check_out("single.out", 1'b1, 3'd2);
    check("single.pending_clr", pending, 8'h00);
    tick();
    check_out("single.end", 1'b0, 3'd0);
    check("single.empty", {7'd0, empty}, 8'h01);
    $display("txn single: req=04 code=2");

    // 3. Ordering, both priority directions
    req = 8'hA1; tick();
    check("order.pending", pending, 8'hA1);
    req = 8'h00; tick();
    check_out("order.c0", 1'b1, 3'd0);
    check("order_hi.c0", {5'd0, code_hi}, 8'd7);
    check("order.pend0", pending, 8'hA0);
    check("order_hi.pend0", pending_hi, 8'h21);
    tick();
    check_out("order.c1", 1'b1, 3'd5);
    check("order_hi.c1", {5'd0, code_hi}, 8'd5);
    tick();
    check_out("order.c2", 1'b1, 3'd7);
    check("order_hi.c2", {5'd0, code_hi}, 8'd0);
    check("order_hi.valid2", {7'd0, valid_hi}, 8'h01);
    tick();
    check_out("order.end", 1'b0, 3'd0);
    check("order_hi.end", {7'd0, valid_hi}, 8'h00);
    $display("txn ordering: lo=0,5,7 hi=7,5,0");

    // 4. Backpressure
    ready = 1'b0; req = 8'h03; tick();
    req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("bp.hold", 1'b1, 3'd0);
      check("bp.pending", pending, 8'h02);
    end
    ready = 1'b1; tick();
    check_out("bp.next", 1'b1, 3'd1);
    check("bp.pending_clr", pending, 8'h00);
    tick();
    check_out("bp.end", 1'b0, 3'd0);
    $display("txn backpressure: hold code=0 then code=1");

    // 5a. Re-request on a bit pending behind a stalled code
    ready = 1'b0; req = 8'h21; tick();
    req = 8'h00; tick();
    check_out("ovf.stall", 1'b1, 3'd0);
    check("ovf.pre", {7'd0, overflow}, 8'h00);
    req = 8'h20; tick();
    check("ovf.set", {7'd0, overflow}, 8'h01);
    check("ovf.pending", pending, 8'h20);
    req = 8'h00; ready = 1'b1; tick();
    check_out("ovf.c5", 1'b1, 3'd5);
    tick();
    check_out("ovf.end", 1'b0, 3'd0);
    check("ovf.sticky", {7'd0, overflow}, 8'h01);
    $display("txn collision-merge: overflow=1 one code 5");

    rst = 1'b1; tick(); rst = 1'b0;
    check("ovf.cleared", {7'd0, overflow}, 8'h00);

    // 5b. Re-request on the same edge the bit is loaded
    req = 8'h20; tick();
    check("same.pending", pending, 8'h20);
    tick();
    check_out("same.c5a", 1'b1, 3'd5);
    check("same.pending_kept", pending, 8'h20);
    req = 8'h00; tick();
    check_out("same.c5b", 1'b1, 3'd5);
    tick();
    check_out("same.end", 1'b0, 3'd0);
    check("same.overflow", {7'd0, overflow}, 8'h00);
    $display("txn collision-same-edge: two code 5, overflow=0");

    // 6a. Enable low ignores requests
    ready = 1'b0; req = 8'h03; tick();
    req = 8'h00; tick();
    e = 1'b0; req = 8'hFF; tick(); tick();
    check("en.pending", pending, 8'h02);
    check("en.overflow", {7'd0, overflow}, 8'h00);
    check_out("en.hold", 1'b1, 3'd0);
    ready = 1'b1; tick();
    check_out("en.drain", 1'b1, 3'd1);
    tick();
    check_out("en.end", 1'b0, 3'd0);
    check("en.empty", {7'd0, empty}, 8'h01);
    e = 1'b1; req = 8'h00;
    $display("txn enable-low: req=FF ignored");

    // 6b. Mid-stream reset
    ready = 1'b0; req = 8'hF1; tick();
    req = 8'h00; tick();
    check_out("mrst.pre", 1'b1, 3'd0);
    check("mrst.pend_pre", pending, 8'hF0);
    rst = 1'b1; ready = 1'b1; tick();
    rst = 1'b0;
    check("mrst.valid", {7'd0, valid}, 8'h00);
    check("mrst.pending", pending, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst.quiet", {7'd0, valid}, 8'h00);
    end
    check("mrst.empty", {7'd0, empty}, 8'h01);
    $display("txn mid-stream reset: cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
